home_inventory_meas_seq: RTL

//  Measurement sequencer behind the home_inventory_wb register block. On each CTRL.START it scans the enabled

---
 rtl/home_inventory_pkg.sv | 27 ++
 rtl/home_inventory_avg_accum.sv | 53 +++++
 rtl/home_inventory_meas_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/home_inventory_pkg.sv
// Shared encodings for the home_inventory measurement path: sequencer states,
// IRQ bit indices and core_status bit positions.
package home_inventory_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_REQ    = 3'd2,
        ST_ACC    = 3'd3,
        ST_EMIT   = 3'd4,
        ST_NEXT   = 3'd5,
        ST_DONE   = 3'd6
    } meas_state_e;

    localparam int IRQ_W    = 3;
    localparam int IRQ_DONE = 0;
    localparam int IRQ_ERR  = 1;
    localparam int IRQ_OVR  = 2;

    localparam int STATUS_BUSY   = 0;
    localparam int STATUS_DONE   = 1;
    localparam int STATUS_ERR    = 2;
    localparam int STATUS_OVR    = 3;
    localparam int STATUS_CH_LSB = 4;
    localparam int STATUS_CH_W   = 4;

endpackage

// File: rtl/home_inventory_avg_accum.sv
// Signed sample accumulator: sums 2^AVG_LOG2 samples and presents the floored
// average (arithmetic shift) together with a "block complete" flag.
module home_inventory_avg_accum
    import home_inventory_pkg::*;
#(
    parameter int SAMPLE_W = 24,
    parameter int AVG_LOG2 = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       add_i,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    output logic                       full_o,
    output logic        [SAMPLE_W-1:0] avg_o
);

    localparam int ACC_W = SAMPLE_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] NUM_SAMPLES = CNT_W'(1 << AVG_LOG2);

    logic signed [ACC_W-1:0] acc_q, acc_d, sample_ext;
    logic        [CNT_W-1:0] cnt_q, cnt_d;

    // Guard bits above SAMPLE_W keep the full block sum exact, so no overflow.
    assign sample_ext = ACC_W'(sample_i);

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (add_i) begin
            acc_d = acc_q + sample_ext;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign full_o = (cnt_q == NUM_SAMPLES);
    assign avg_o  = SAMPLE_W'(acc_q >>> AVG_LOG2);

endmodule

// File: rtl/home_inventory_meas_seq.sv
// Measurement sequencer: scans enabled load-cell channels, drives the ADC
// req/ack handshake, averages samples per channel and raises masked IRQs.
module home_inventory_meas_seq
    import home_inventory_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SAMPLE_W    = 24,
    parameter int AVG_LOG2    = 2,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_ni,
    input  logic                       ctrl_enable,
    input  logic                       ctrl_start,
    input  logic [IRQ_W-1:0]           irq_en,
    input  logic [IRQ_W-1:0]           irq_clr_i,
    input  logic [NUM_CH-1:0]          ch_mask_i,
    output logic                       adc_req_o,
    output logic [$clog2(NUM_CH)-1:0]  adc_ch_o,
    input  logic                       adc_ack_i,
    input  logic signed [SAMPLE_W-1:0] adc_data_i,
    output logic                       res_valid_o,
    output logic [$clog2(NUM_CH)-1:0]  res_ch_o,
    output logic [SAMPLE_W-1:0]        res_data_o,
    output logic [7:0]                 status_o,
    output logic                       irq_o
);

    localparam int CH_W    = $clog2(NUM_CH);
    localparam int TMR_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    meas_state_e         state_q, state_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [CH_W-1:0]     cur_ch_q, cur_ch_d, adc_ch_q, adc_ch_d, res_ch_q, res_ch_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                req_q, req_d, res_valid_q, res_valid_d;
    logic [SAMPLE_W-1:0] res_data_q, res_data_d;
    logic                done_q, done_d, err_q, err_d, ovr_q, ovr_d;
    logic [IRQ_W-1:0]    irq_pend_q, irq_pend_d, irq_set;

    logic                start_ok, abort, sample_take, timeout, acc_clr, acc_full;
    logic [SAMPLE_W-1:0] acc_avg;
    logic                first_found, next_found;
    logic [CH_W-1:0]     first_ch, next_ch;

    // Lowest set bit of the incoming mask, and the next set bit above cur_ch.
    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        next_found  = 1'b0;
        next_ch     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask_i[i]) begin
                first_found = 1'b1;
                first_ch    = CH_W'(i);
            end
            if (mask_q[i] && (i > int'(cur_ch_q))) begin
                next_found = 1'b1;
                next_ch    = CH_W'(i);
            end
        end
    end

    assign start_ok    = ctrl_start && ctrl_enable;
    assign abort       = (state_q != ST_IDLE) && !ctrl_enable;
    assign sample_take = (state_q == ST_REQ) && adc_ack_i;
    assign timeout     = (state_q == ST_REQ) && !adc_ack_i && (timer_q == TMR_W'(TIMEOUT_CYC - 1));
    assign acc_clr     = (state_q == ST_EMIT) || abort || timeout;

    home_inventory_avg_accum #(
        .SAMPLE_W (SAMPLE_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .clk_i    (wb_clk_i),
        .rst_ni   (wb_rst_ni),
        .clr_i    (acc_clr),
        .add_i    (sample_take),
        .sample_i (adc_data_i),
        .full_o   (acc_full),
        .avg_o    (acc_avg)
    );

    // Next-state and registered-output logic; an enable drop overrides everything.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        cur_ch_d    = cur_ch_q;
        adc_ch_d    = adc_ch_q;
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;
        timer_d     = timer_q + TMR_W'(1);
        req_d       = req_q;
        res_valid_d = 1'b0;
        done_d      = done_q;
        err_d       = err_q;
        ovr_d       = ovr_q;
        irq_set     = '0;

        if (abort) begin
            state_d  = ST_IDLE;
            req_d    = 1'b0;
            cur_ch_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        mask_d   = ch_mask_i;
                        done_d   = 1'b0;
                        err_d    = 1'b0;
                        ovr_d    = 1'b0;
                        cur_ch_d = first_ch;
                        timer_d  = '0;
                        state_d  = first_found ? ST_SETTLE : ST_DONE;
                    end
                end
                ST_SETTLE: begin
                    if (timer_q == TMR_W'(SETTLE_CYC - 1)) begin
                        state_d  = ST_REQ;
                        req_d    = 1'b1;
                        adc_ch_d = cur_ch_q;
                        timer_d  = '0;
                    end
                end
                ST_REQ: begin
                    if (adc_ack_i) begin
                        state_d = ST_ACC;
                        req_d   = 1'b0;
                    end else if (timeout) begin
                        state_d          = ST_IDLE;
                        req_d            = 1'b0;
                        err_d            = 1'b1;
                        cur_ch_d         = '0;
                        irq_set[IRQ_ERR] = 1'b1;
                    end
                end
                ST_ACC: begin
                    if (acc_full) begin
                        state_d = ST_EMIT;
                    end else begin
                        state_d = ST_REQ;
                        req_d   = 1'b1;
                        timer_d = '0;
                    end
                end
                ST_EMIT: begin
                    res_valid_d = 1'b1;
                    res_ch_d    = cur_ch_q;
                    res_data_d  = acc_avg;
                    state_d     = ST_NEXT;
                end
                ST_NEXT: begin
                    if (next_found) begin
                        cur_ch_d = next_ch;
                        adc_ch_d = next_ch;
                        req_d    = 1'b1;
                        timer_d  = '0;
                        state_d  = ST_REQ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_d            = 1'b1;
                    cur_ch_d          = '0;
                    irq_set[IRQ_DONE] = 1'b1;
                    state_d           = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (start_ok && (state_q != ST_IDLE)) begin
            ovr_d            = 1'b1;
            irq_set[IRQ_OVR] = 1'b1;
        end

        irq_pend_d = (irq_pend_q & ~irq_clr_i) | irq_set;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            cur_ch_q    <= '0;
            adc_ch_q    <= '0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
            timer_q     <= '0;
            req_q       <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ovr_q       <= 1'b0;
            irq_pend_q  <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            cur_ch_q    <= cur_ch_d;
            adc_ch_q    <= adc_ch_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
            timer_q     <= timer_d;
            req_q       <= req_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ovr_q       <= ovr_d;
            irq_pend_q  <= irq_pend_d;
        end
    end

    always_comb begin
        status_o                                   = '0;
        status_o[STATUS_BUSY]                      = (state_q != ST_IDLE);
        status_o[STATUS_DONE]                      = done_q;
        status_o[STATUS_ERR]                       = err_q;
        status_o[STATUS_OVR]                       = ovr_q;
        status_o[STATUS_CH_LSB +: STATUS_CH_W]     = STATUS_CH_W'(cur_ch_q);
    end

    assign adc_req_o   = req_q;
    assign adc_ch_o    = adc_ch_q;
    assign res_valid_o = res_valid_q;
    assign res_ch_o    = res_ch_q;
    assign res_data_o  = res_data_q;
    assign irq_o       = |(irq_pend_q & irq_en);

endmodule
